// File: rtl/a23_out_unloader.sv
// -----------------------------------------------------------------------------
// a23_out_unloader
//
// Downstream consumer of a23_gc_main. Counts clock cycles from reset release
// until `terminate` rises, snapshots the flat output memory `o` on that edge,
// then streams the snapshot one 32-bit word per beat over a valid/ready
// interface to a host-side sink.
//
// Optional feature (compile-time macro A23_UNLOAD_CC_HEADER_EN):
//   when defined, the stream starts with a header beat carrying the frozen
//   cycle count (zero-extended/truncated to 32 bits) at out_addr = all-ones,
//   followed by the OUT_MEM_SIZE memory beats. When undefined, the stream is
//   exactly OUT_MEM_SIZE beats starting at out_addr = 0.
//
// Parameters:
//   OUT_MEM_SIZE  number of 32-bit words in `o` (>= 2)
//   CC_WIDTH      width of the cycle counter
//   ADDR_WIDTH    width of out_addr (2**ADDR_WIDTH >= OUT_MEM_SIZE)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   o            flat output memory, word i at o[32*i +: 32]
//   terminate    program-finished flag
//   out_valid    beat available
//   out_ready    sink accepts beat
//   out_data     beat payload
//   out_addr     word index of current beat (all-ones for the header beat)
//   out_last     high on the final beat
//   cycle_count  cycles counted before terminate; frozen after capture
//   done         all beats transferred
//
// States:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_COUNT  | counting cycles, waiting for terminate; captures `o` on exit
//   ST_STREAM | presenting snapshot beats, advancing on out_valid&&out_ready
//   ST_DONE   | all beats transferred; holds until reset
// -----------------------------------------------------------------------------
module a23_out_unloader #(
    parameter int OUT_MEM_SIZE = 64,
    parameter int CC_WIDTH     = 32,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OUT_MEM_SIZE*32-1:0] o,
    input  logic                       terminate,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic                       out_last,
    output logic [CC_WIDTH-1:0]        cycle_count,
    output logic                       done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUT_MEM_SIZE - 1);

    typedef enum logic [1:0] {
        ST_COUNT  = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic [31:0]             snap [OUT_MEM_SIZE];
    logic                    capture;
    logic [ADDR_WIDTH-1:0]   idx_next;

    assign capture = (state == ST_COUNT) && terminate;

    // out_addr doubles as the stream index. The header beat sits at
    // all-ones, so +1 wraps it to 0 and the first memory beat follows
    // without a separate header flag.
    assign idx_next = out_addr + ADDR_WIDTH'(1);

`ifdef A23_UNLOAD_CC_HEADER_EN
    logic [31:0] hdr_word;

    generate
        if (CC_WIDTH >= 32) begin : g_hdr_trunc
            assign hdr_word = cycle_count[31:0];
        end else begin : g_hdr_zext
            assign hdr_word = {{(32 - CC_WIDTH){1'b0}}, cycle_count};
        end
    endgenerate
`endif

    // Snapshot buffer: plain register array with no reset, its contents are
    // only read after a capture has loaded them.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < OUT_MEM_SIZE; i++) begin
                snap[i] <= o[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_COUNT;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            cycle_count <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (terminate) begin
                        // Counter freezes on the capture edge. The first beat
                        // comes straight from `o` (or the frozen count) since
                        // the snapshot is being written on this same edge.
                        state     <= ST_STREAM;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
`ifdef A23_UNLOAD_CC_HEADER_EN
                        out_data  <= hdr_word;
                        out_addr  <= '1;
`else
                        out_data  <= o[31:0];
                        out_addr  <= '0;
`endif
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CC_WIDTH'(1);
                    end
                end

                ST_STREAM: begin
                    // out_valid is always high here, so out_ready alone
                    // marks a transfer; without one everything holds.
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_data <= snap[idx_next];
                            out_addr <= idx_next;
                            out_last <= (idx_next == LAST_IDX);
                        end
                    end
                end

                ST_DONE: begin
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end

                default: begin
                    state <= ST_COUNT;
                end
            endcase
        end
    end

endmodule
